// File: rtl/cmac_seq.sv
// cmac_seq: complex multiply-accumulate sequencer.
// Walks two synchronous-read memories with independent base/stride addressing
// and accumulates the complex dot product of L pairs with saturation.
//
// Control handshake: start is sampled on every rising edge, but a start is
// accepted only in IDLE. Configuration is captured in that same cycle. busy is
// high from the cycle after the accepting edge up to and including the
// one-cycle done strobe. Starts seen while busy is high are dropped.
module cmac_seq #(
  parameter int DW         = 32,
  parameter int FRAC       = 27,
  parameter int AW         = 48,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH:0]          len,
  input  logic                         conj,
  input  logic [ADDR_WIDTH-1:0]        base_a,
  input  logic [ADDR_WIDTH-1:0]        base_b,
  input  logic [ADDR_WIDTH-1:0]        stride_a,
  input  logic [ADDR_WIDTH-1:0]        stride_b,
  output logic [ADDR_WIDTH-1:0]        addr_a,
  output logic [ADDR_WIDTH-1:0]        addr_b,
  input  logic signed [DW-1:0]         a_re,
  input  logic signed [DW-1:0]         a_im,
  input  logic signed [DW-1:0]         b_re,
  input  logic signed [DW-1:0]         b_im,
  output logic                         busy,
  output logic                         done,
  output logic signed [AW-1:0]         acc_re,
  output logic signed [AW-1:0]         acc_im,
  output logic                         ovf,
  output logic [1:0]                   dbg_state
);

  localparam int PW = 2 * DW;                        // product width
  localparam int TW = PW + 1;                        // combined term width
  localparam int SW = ((AW > TW) ? AW : TW) + 1;     // accumulate sum width

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-AW+1){1'b1}}, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Adds a term to the accumulator; returns {clamped, saturated_sum}.
  function automatic logic [AW:0] sat_add(input logic signed [AW-1:0] acc,
                                          input logic signed [TW-1:0] term);
    logic signed [SW-1:0] s;
    s = {{(SW-AW){acc[AW-1]}}, acc} + {{(SW-TW){term[TW-1]}}, term};
    if (s > SAT_MAX) begin
      sat_add = {1'b1, SAT_MAX[AW-1:0]};
    end else if (s < SAT_MIN) begin
      sat_add = {1'b1, SAT_MIN[AW-1:0]};
    end else begin
      sat_add = {1'b0, s[AW-1:0]};
    end
  endfunction

  // Control state
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                    conj_q, conj_d;
  logic [ADDR_WIDTH-1:0]   stride_a_q, stride_a_d;
  logic [ADDR_WIDTH-1:0]   stride_b_q, stride_b_d;
  logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0]   addr_b_q, addr_b_d;
  logic [1:0]              dcnt_q, dcnt_d;
  logic                    issue_q, issue_d;   // an address was issued this cycle
  logic                    vd_q, vd_d;         // memory data valid
  logic                    vp_q, vp_d;         // products valid
  logic                    vc_q, vc_d;         // combined term valid
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    accept;

  // Datapath state
  logic signed [PW-1:0]    rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;
  logic signed [TW-1:0]    term_re_q, term_re_d, term_im_q, term_im_d;
  logic signed [AW-1:0]    acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic                    ovf_q, ovf_d;

  logic signed [PW-1:0]    a_re_x, a_im_x, b_re_x, b_im_x;
  logic signed [TW-1:0]    rr_x, ii_x, ri_x, ir_x, re_sum, im_sum;
  logic [AW:0]             sum_re, sum_im;

  // Sequencing: accept start, issue L addresses, wait for the pipeline, strobe done
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    conj_d     = conj_q;
    stride_a_d = stride_a_q;
    stride_b_d = stride_b_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    dcnt_d     = dcnt_q;
    issue_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    accept     = 1'b0;
    vd_d       = issue_q;
    vp_d       = vd_q;
    vc_d       = vp_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          len_d      = len;
          conj_d     = conj;
          stride_a_d = stride_a;
          stride_b_d = stride_b;
          addr_a_d   = base_a;
          addr_b_d   = base_b;
          cnt_d      = {{ADDR_WIDTH{1'b0}}, 1'b1};
          busy_d     = 1'b1;
          if (len == '0) begin
            // Nothing to fetch: report the cleared result right away.
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            issue_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == len_q) begin
          state_d = ST_DRAIN;
          dcnt_d  = 2'd0;
        end else begin
          addr_a_d = addr_a_q + stride_a_q;
          addr_b_d = addr_b_q + stride_b_q;
          cnt_d    = cnt_q + 1'b1;
          issue_d  = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Three edges after the last address the final term lands in the accumulator.
        if (dcnt_q == 2'd2) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM and control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      conj_q     <= 1'b0;
      stride_a_q <= '0;
      stride_b_q <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      dcnt_q     <= 2'd0;
      issue_q    <= 1'b0;
      vd_q       <= 1'b0;
      vp_q       <= 1'b0;
      vc_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      conj_q     <= conj_d;
      stride_a_q <= stride_a_d;
      stride_b_q <= stride_b_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      dcnt_q     <= dcnt_d;
      issue_q    <= issue_d;
      vd_q       <= vd_d;
      vp_q       <= vp_d;
      vc_q       <= vc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Products, conjugate-aware combine with floor shift, saturating accumulate
  always_comb begin
    a_re_x = {{DW{a_re[DW-1]}}, a_re};
    a_im_x = {{DW{a_im[DW-1]}}, a_im};
    b_re_x = {{DW{b_re[DW-1]}}, b_re};
    b_im_x = {{DW{b_im[DW-1]}}, b_im};
    rr_d   = a_re_x * b_re_x;
    ii_d   = a_im_x * b_im_x;
    ri_d   = a_re_x * b_im_x;
    ir_d   = a_im_x * b_re_x;

    rr_x = {rr_q[PW-1], rr_q};
    ii_x = {ii_q[PW-1], ii_q};
    ri_x = {ri_q[PW-1], ri_q};
    ir_x = {ir_q[PW-1], ir_q};
    if (conj_q) begin
      re_sum = rr_x + ii_x;
      im_sum = ir_x - ri_x;
    end else begin
      re_sum = rr_x - ii_x;
      im_sum = ri_x + ir_x;
    end
    term_re_d = re_sum >>> FRAC;
    term_im_d = im_sum >>> FRAC;

    sum_re   = sat_add(acc_re_q, term_re_q);
    sum_im   = sat_add(acc_im_q, term_im_q);
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    ovf_d    = ovf_q;
    if (accept) begin
      acc_re_d = '0;
      acc_im_d = '0;
      ovf_d    = 1'b0;
    end else if (vc_q) begin
      acc_re_d = sum_re[AW-1:0];
      acc_im_d = sum_im[AW-1:0];
      ovf_d    = ovf_q | sum_re[AW] | sum_im[AW];
    end
  end

  // Datapath pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q      <= '0;
      ii_q      <= '0;
      ri_q      <= '0;
      ir_q      <= '0;
      term_re_q <= '0;
      term_im_q <= '0;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      ii_q      <= ii_d;
      ri_q      <= ri_d;
      ir_q      <= ir_d;
      term_re_q <= term_re_d;
      term_im_q <= term_im_d;
      acc_re_q  <= acc_re_d;
      acc_im_q  <= acc_im_d;
      ovf_q     <= ovf_d;
    end
  end

  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign acc_re    = acc_re_q;
  assign acc_im    = acc_im_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cmac_seq.sv
// tb_cmac_seq: directed bench for cmac_seq with a synchronous-read ROM model.
// A second instance with a 36-bit accumulator exercises saturation.
module tb_cmac_seq;

  localparam longint ONE   = 64'sd134217728;   // 1.0 with 27 fractional bits
  localparam int     ONE_I = 134217728;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        conj = 1'b0;
  logic [4:0]  len = '0;
  logic [3:0]  base_a = '0, base_b = '0, stride_a = '0, stride_b = '0;

  logic [3:0]  addr_a, addr_b, s_addr_a, s_addr_b;
  logic signed [31:0] a_re, a_im, b_re, b_im;
  logic signed [31:0] s_a_re, s_a_im, s_b_re, s_b_im;
  logic        busy, done, ovf, s_busy, s_done, s_ovf;
  logic signed [47:0] acc_re, acc_im;
  logic signed [35:0] s_acc_re, s_acc_im;
  logic [1:0]  dbg_state, s_dbg_state;

  logic signed [31:0] ma_re [16];
  logic signed [31:0] ma_im [16];
  logic signed [31:0] mb_re [16];
  logic signed [31:0] mb_im [16];

  int n_checks = 0;
  int n_fail   = 0;

  // Clock
  always #5 clk = ~clk;

  // Synchronous-read ROMs, one read port per instance
  always @(posedge clk) begin
    a_re   <= ma_re[addr_a];   a_im   <= ma_im[addr_a];
    b_re   <= mb_re[addr_b];   b_im   <= mb_im[addr_b];
    s_a_re <= ma_re[s_addr_a]; s_a_im <= ma_im[s_addr_a];
    s_b_re <= mb_re[s_addr_b]; s_b_im <= mb_im[s_addr_b];
  end

  cmac_seq u_dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .conj(conj),
    .base_a(base_a), .base_b(base_b), .stride_a(stride_a), .stride_b(stride_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .busy(busy), .done(done), .acc_re(acc_re), .acc_im(acc_im), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  cmac_seq #(.AW(36)) u_sat (
    .clk(clk), .rst(rst), .start(start), .len(len), .conj(conj),
    .base_a(base_a), .base_b(base_b), .stride_a(stride_a), .stride_b(stride_b),
    .addr_a(s_addr_a), .addr_b(s_addr_b),
    .a_re(s_a_re), .a_im(s_a_im), .b_re(s_b_re), .b_im(s_b_im),
    .busy(s_busy), .done(s_done), .acc_re(s_acc_re), .acc_im(s_acc_im), .ovf(s_ovf),
    .dbg_state(s_dbg_state)
  );

  // Reference dot product (no saturation; used only where values stay small)
  function automatic void model_dot(input int n, input int ba, input int sa,
                                    input int bb, input int sb, input bit cj,
                                    output longint er, output longint ei);
    er = 0;
    ei = 0;
    for (int k = 0; k < n; k++) begin
      int ia, ib;
      longint rr, ii, ri, ir;
      ia = (ba + k * sa) % 16;
      ib = (bb + k * sb) % 16;
      rr = longint'(ma_re[ia]) * longint'(mb_re[ib]);
      ii = longint'(ma_im[ia]) * longint'(mb_im[ib]);
      ri = longint'(ma_re[ia]) * longint'(mb_im[ib]);
      ir = longint'(ma_im[ia]) * longint'(mb_re[ib]);
      if (cj) begin
        er += (rr + ii) >>> 27;
        ei += (ir - ri) >>> 27;
      end else begin
        er += (rr - ii) >>> 27;
        ei += (ri + ir) >>> 27;
      end
    end
  endfunction

  task automatic fill_pattern();
    for (int i = 0; i < 16; i++) begin
      ma_re[i] = (i - 5) * (ONE_I / 2) + i * 3;
      ma_im[i] = (3 - i) * (ONE_I / 4) - i;
      mb_re[i] = (i % 7 - 3) * (ONE_I / 3);
      mb_im[i] = (2 * i - 15) * (ONE_I / 8) + 7;
    end
  endtask

  task automatic fill_const(input int ar, input int ai, input int br, input int bi);
    for (int i = 0; i < 16; i++) begin
      ma_re[i] = ar; ma_im[i] = ai; mb_re[i] = br; mb_im[i] = bi;
    end
  endtask

  // Drive a one-cycle start; returns at the falling edge after the accepting edge.
  task automatic do_start(input int l, input bit cj, input int ba, input int sa,
                          input int bb, input int sb);
    @(negedge clk);
    start = 1'b1; len = 5'(l); conj = cj;
    base_a = 4'(ba); stride_a = 4'(sa); base_b = 4'(bb); stride_b = 4'(sb);
    @(negedge clk);
    start    = 1'b0;
    len      = 5'($urandom_range(0, 16));
    conj     = 1'($urandom_range(0, 1));
    base_a   = 4'($urandom_range(0, 15));
    base_b   = 4'($urandom_range(0, 15));
    stride_a = 4'($urandom_range(0, 15));
    stride_b = 4'($urandom_range(0, 15));
  endtask

  // Count edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(input int n0, input int budget, output int n, output bit to);
    n  = n0;
    to = 1'b0;
    while (done !== 1'b1) begin
      if (n >= budget) begin
        to = 1'b1;
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, ovf} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000", {busy, done, ovf});
    end
    n_checks++;
    if ({addr_a, addr_b} !== 8'h00) begin
      n_fail++; $display("FAIL reset_addr: got %h required 00", {addr_a, addr_b});
    end
    n_checks++;
    if (acc_re !== 48'sd0 || acc_im !== 48'sd0) begin
      n_fail++; $display("FAIL reset_acc: got %0d/%0d required 0/0", acc_re, acc_im);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int n; bit to;
    fill_const(0, 0, 0, 0);
    ma_re[0] = ONE_I; ma_im[0] = 2 * ONE_I; mb_re[0] = 3 * ONE_I; mb_im[0] = -ONE_I;
    do_start(1, 1'b0, 0, 0, 0, 0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", busy); end
    wait_done(0, 40, n, to);
    n_checks++;
    if (to || n != 4) begin n_fail++; $display("FAIL basic_latency: got %0d (timeout %0d) required 4", n, to); end
    n_checks++;
    if (acc_re !== 48'(5 * ONE) || acc_im !== 48'(5 * ONE) || ovf !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_result: got %0d/%0d ovf %b busy %b required %0d/%0d ovf 0 busy 1",
               acc_re, acc_im, ovf, busy, 5 * ONE, 5 * ONE);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || acc_re !== 48'(5 * ONE)) begin
      n_fail++; $display("FAIL basic_after_done: got done %b busy %b acc %0d required 0 0 %0d", done, busy, acc_re, 5 * ONE);
    end
    // Conjugate of B: (1+2j)(3+1j) = 1+7j
    do_start(1, 1'b1, 0, 0, 0, 0);
    wait_done(0, 40, n, to);
    n_checks++;
    if (to || n != 4 || acc_re !== 48'(ONE) || acc_im !== 48'(7 * ONE)) begin
      n_fail++;
      $display("FAIL conj_result: got n=%0d %0d/%0d required n=4 %0d/%0d", n, acc_re, acc_im, ONE, 7 * ONE);
    end
  endtask

  task automatic test_trunc();
    int n; bit to;
    fill_const(0, 0, 0, 0);
    ma_re[0] = -1; mb_re[0] = 1;   // product -2^-54 floors to -1 LSB
    do_start(1, 1'b0, 0, 0, 0, 0);
    wait_done(0, 40, n, to);
    n_checks++;
    if (to || acc_re !== -48'sd1 || acc_im !== 48'sd0) begin
      n_fail++; $display("FAIL trunc_floor: got %0d/%0d required -1/0", acc_re, acc_im);
    end
  endtask

  task automatic test_stride();
    int n; bit to; longint er, ei;
    fill_pattern();
    do_start(4, 1'b0, 14, 1, 0, 4);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (addr_a !== 4'((14 + k) % 16) || addr_b !== 4'((4 * k) % 16)) begin
        n_fail++;
        $display("FAIL stride_addr_%0d: got %0d/%0d required %0d/%0d", k, addr_a, addr_b, (14 + k) % 16, (4 * k) % 16);
      end
      if (k < 3) @(negedge clk);
    end
    wait_done(3, 40, n, to);
    model_dot(4, 14, 1, 0, 4, 1'b0, er, ei);
    n_checks++;
    if (to || n != 7) begin n_fail++; $display("FAIL stride_latency: got %0d required 7", n); end
    n_checks++;
    if (acc_re !== 48'(er) || acc_im !== 48'(ei) || ovf !== 1'b0) begin
      n_fail++; $display("FAIL stride_result: got %0d/%0d ovf %b required %0d/%0d", acc_re, acc_im, ovf, er, ei);
    end
  endtask

  task automatic test_len0_busy();
    int n; bit to; int ndone; int first; longint er, ei;
    do_start(0, 1'b0, 5, 1, 5, 1);
    wait_done(0, 40, n, to);
    n_checks++;
    if (to || n != 0 || acc_re !== 48'sd0 || acc_im !== 48'sd0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL len0: got n=%0d %0d/%0d ovf %b required n=0 0/0 ovf 0", n, acc_re, acc_im, ovf);
    end
    // L=8 with extra starts injected while busy
    do_start(8, 1'b0, 0, 1, 0, 1);
    ndone = 0;
    first = -1;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = c;
      end
      if (c == 2 || c == 5) begin
        start = 1'b1; len = 5'd1; conj = 1'b1; base_a = 4'd3; base_b = 4'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    model_dot(8, 0, 1, 0, 1, 1'b0, er, ei);
    n_checks++;
    if (ndone != 1 || first != 11) begin
      n_fail++; $display("FAIL busy_ignore_done: got %0d dones first at %0d required 1 at 11", ndone, first);
    end
    n_checks++;
    if (acc_re !== 48'(er) || acc_im !== 48'(ei)) begin
      n_fail++; $display("FAIL busy_ignore_acc: got %0d/%0d required %0d/%0d", acc_re, acc_im, er, ei);
    end
  endtask

  task automatic test_sat();
    int n; bit to;
    fill_const(15 * ONE_I, 0, 15 * ONE_I, 0);
    do_start(2, 1'b0, 0, 1, 0, 1);
    wait_done(0, 40, n, to);
    n_checks++;
    if (to || n != 5 || s_done !== 1'b1) begin
      n_fail++; $display("FAIL sat_latency: got %0d done %b required 5 done 1", n, s_done);
    end
    n_checks++;
    if (s_acc_re !== 36'sh7FFFFFFFF || s_acc_im !== 36'sd0 || s_ovf !== 1'b1) begin
      n_fail++; $display("FAIL sat_pos: got %0d/%0d ovf %b required 34359738367/0 ovf 1", s_acc_re, s_acc_im, s_ovf);
    end
    n_checks++;
    if (acc_re !== 48'(450 * ONE) || ovf !== 1'b0) begin
      n_fail++; $display("FAIL sat_wide: got %0d ovf %b required %0d ovf 0", acc_re, ovf, 450 * ONE);
    end
    // Negative clamp through the conjugate imaginary path
    fill_const(15 * ONE_I, 0, 0, 15 * ONE_I);
    do_start(2, 1'b1, 0, 1, 0, 1);
    wait_done(0, 40, n, to);
    n_checks++;
    if (to || s_acc_im !== 36'sh800000000 || s_acc_re !== 36'sd0 || s_ovf !== 1'b1) begin
      n_fail++; $display("FAIL sat_neg: got %0d/%0d ovf %b required 0/-34359738368 ovf 1", s_acc_re, s_acc_im, s_ovf);
    end
    n_checks++;
    if (acc_im !== 48'(-450 * ONE)) begin
      n_fail++; $display("FAIL sat_neg_wide: got %0d required %0d", acc_im, -450 * ONE);
    end
    do_start(0, 1'b0, 0, 0, 0, 0);
    wait_done(0, 40, n, to);
    n_checks++;
    if (to || s_ovf !== 1'b0 || s_acc_re !== 36'sd0 || s_acc_im !== 36'sd0) begin
      n_fail++; $display("FAIL sat_clear: got ovf %b acc %0d/%0d required 0 0/0", s_ovf, s_acc_re, s_acc_im);
    end
  endtask

  task automatic test_reset_mid();
    int n; bit to; int ndone; longint er, ei;
    fill_pattern();
    do_start(8, 1'b0, 0, 1, 0, 1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, ovf} !== 3'b000 || {addr_a, addr_b} !== 8'h00 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_ctrl: got flags %b addr %h state %0d required 000 00 0", {busy, done, ovf}, {addr_a, addr_b}, dbg_state);
    end
    n_checks++;
    if (acc_re !== 48'sd0 || acc_im !== 48'sd0) begin
      n_fail++; $display("FAIL reset_mid_acc: got %0d/%0d required 0/0", acc_re, acc_im);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin n_fail++; $display("FAIL reset_mid_nodone: got %0d dones required 0", ndone); end
    do_start(4, 1'b1, 2, 3, 5, 7);
    wait_done(0, 40, n, to);
    model_dot(4, 2, 3, 5, 7, 1'b1, er, ei);
    n_checks++;
    if (to || n != 7 || acc_re !== 48'(er) || acc_im !== 48'(ei)) begin
      n_fail++; $display("FAIL reset_mid_after: got n=%0d %0d/%0d required n=7 %0d/%0d", n, acc_re, acc_im, er, ei);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit to; longint er, ei;
    do_start(1, 1'b0, 6, 0, 9, 0);
    wait_done(0, 40, n, to);
    model_dot(1, 6, 0, 9, 0, 1'b0, er, ei);
    n_checks++;
    if (to || acc_re !== 48'(er) || acc_im !== 48'(ei)) begin
      n_fail++; $display("FAIL b2b_first: got %0d/%0d required %0d/%0d", acc_re, acc_im, er, ei);
    end
    // Start raised during the done cycle and held one more cycle
    start = 1'b1; len = 5'd2; conj = 1'b0;
    base_a = 4'd1; stride_a = 4'd1; base_b = 4'd1; stride_b = 4'd1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ignored_in_done: got busy %b done %b required 0 0", busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy %b required 1", busy); end
    wait_done(0, 40, n, to);
    model_dot(2, 1, 1, 1, 1, 1'b0, er, ei);
    n_checks++;
    if (to || n != 5 || acc_re !== 48'(er) || acc_im !== 48'(ei)) begin
      n_fail++; $display("FAIL b2b_second: got n=%0d %0d/%0d required n=5 %0d/%0d", n, acc_re, acc_im, er, ei);
    end
  endtask

  // Test sequence and report
  initial begin
    fill_const(0, 0, 0, 0);
    test_reset();
    test_basic();
    test_trunc();
    test_stride();
    test_len0_busy();
    test_sat();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
